// File: rtl/booth_r16_pkg.sv
// Shared types and helpers for the radix-16 Booth sequential multiplier.
package booth_r16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIN_W = 5;
  // Widest product supported; callers size-cast the result down to 2*LENGTH.
  localparam int MAX_W = 128;

  function automatic logic [MAX_W-1:0] sext_shift(input logic signed [MAX_W-1:0] pp,
                                                  input logic [7:0]              k);
    return pp <<< {k, 2'b00};
  endfunction

endpackage

// File: rtl/booth_r16_seq_ctrl_if.sv
// Operand/product handshake bundle; directions named from the controller's side.
interface booth_r16_seq_ctrl_if #(
  parameter int LENGTH = 8
);
  logic                  valid_i;
  logic                  ready_o;
  logic [LENGTH-1:0]     a_i;
  logic [LENGTH-1:0]     b_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [2*LENGTH-1:0]   p_o;
  logic                  busy_o;

  modport master (
    output valid_i, a_i, b_i, ready_i,
    input  ready_o, valid_o, p_o, busy_o
  );

  modport slave (
    input  valid_i, a_i, b_i, ready_i,
    output ready_o, valid_o, p_o, busy_o
  );
endinterface

// File: rtl/Booth_Ctrl.sv
// Radix-16 Booth digit decode of one 5-bit window and partial product a*d, d in -8..+8.
module Booth_Ctrl
  import booth_r16_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH-1:0] a_i,
  input  logic [WIN_W-1:0]  b_i,
  output logic [LENGTH+3:0] bo_o
);

  logic signed [4:0]        d;
  logic signed [LENGTH+3:0] a_ext;
  logic signed [LENGTH+3:0] d_ext;

  // d = -8*b4 + 4*b3 + 2*b2 + b1 + b0: the upper four bits read as a signed nibble.
  assign d     = $signed({b_i[4], b_i[4:1]}) + $signed({4'b0000, b_i[0]});
  assign a_ext = {{4{a_i[LENGTH-1]}}, a_i};
  assign d_ext = {{(LENGTH-1){d[4]}}, d};
  assign bo_o  = a_ext * d_ext;

endmodule

// File: rtl/booth_r16_seq_ctrl.sv
// Sequential radix-16 Booth multiplier: one window per cycle, product after NWIN+1 cycles.
module booth_r16_seq_ctrl
  import booth_r16_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  booth_r16_seq_ctrl_if.slave  bus
);

  localparam int NWIN = LENGTH / 4;
  localparam int PW   = 2 * LENGTH;
  localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWIN - 1);

  if (LENGTH < 8 || (LENGTH % 4) != 0 || PW > MAX_W) begin : g_bad_length
    $error("booth_r16_seq_ctrl: LENGTH must be a multiple of 4, at least 8");
  end

  state_t              state_q, state_d;
  logic [LENGTH-1:0]   a_q, a_d, b_q, b_d;
  logic [KW-1:0]       k_q, k_d;
  logic [PW-1:0]       acc_q, acc_d, p_q, p_d;
  logic [LENGTH:0]     b_ext;
  logic [WIN_W-1:0]    win;
  logic [LENGTH+3:0]   pp;
  logic [MAX_W-1:0]    pp_w;
  logic                accept;

  // b[-1] = 0 appended below the LSB so window k starts at bit 4k of b_ext.
  assign b_ext = {b_q, 1'b0};
  assign win   = b_ext[{k_q, 2'b00} +: WIN_W];
  assign pp_w  = {{(MAX_W-LENGTH-4){pp[LENGTH+3]}}, pp};

  Booth_Ctrl #(.LENGTH(LENGTH)) u_booth (
    .a_i  (a_q),
    .b_i  (win),
    .bo_o (pp)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    acc_d       = acc_q;
    p_d         = p_q;
    accept      = 1'b0;
    bus.ready_o = 1'b0;
    bus.valid_o = 1'b0;
    bus.busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        accept      = bus.valid_i;
      end
      CALC: begin
        bus.busy_o = 1'b1;
        acc_d      = acc_q + PW'(sext_shift(pp_w, 8'(k_q)));
        k_d        = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = DONE;
          p_d     = acc_d;
          k_d     = '0;
        end
      end
      DONE: begin
        // Accepting a new pair in the same cycle the product leaves avoids an IDLE bubble.
        bus.valid_o = 1'b1;
        bus.ready_o = bus.ready_i;
        if (bus.ready_i) begin
          accept = bus.valid_i;
          if (!bus.valid_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      a_d     = bus.a_i;
      b_d     = bus.b_i;
      acc_d   = '0;
      k_d     = '0;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign bus.p_o = p_q;

endmodule

// File: doc/booth_r16_seq_ctrl.md
Name: booth_r16_seq_ctrl

Overview:
- Sequential radix-16 Booth multiplier controller for signed LENGTH x LENGTH multiplication.
- Accepts an operand pair over a valid/ready handshake and walks the multiplier b in 5-bit overlapping windows, one window per clock.
- Each window feeds one Booth_Ctrl instance, which returns the partial product a*d (d in -8..+8). The controller shifts and accumulates these and presents a 2*LENGTH-bit product over an output valid/ready handshake.

Parameters:
- LENGTH, 8, operand width in bits. Must be a multiple of 4 and at least 8. Elaboration fails otherwise.
- NWIN, LENGTH/4, number of radix-16 windows (derived; not overridable).

Ports:
- clk_i  in  1  clock; all flops are rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  operand pair valid.
- ready_o  out  1  controller can accept an operand pair.
- a_i  in  LENGTH  multiplicand, two's complement.
- b_i  in  LENGTH  multiplier, two's complement.
- valid_o  out  1  product valid.
- ready_i  in  1  downstream accepts the product.
- p_o  out  2*LENGTH  signed product a*b.
- busy_o  out  1  high while in CALC.

Behaviour:
- Reset values: state=IDLE, ready_o=1, valid_o=0, busy_o=0, p_o=0, window counter k=0, accumulator=0, a/b registers=0.
- Reset is honoured in every state. Asserting it mid-CALC discards the operation and produces no output.
- FSM states are IDLE, CALC, DONE.
- IDLE: ready_o=1. On valid_i&ready_o, register a_i and b_i, clear acc, set k=0, go to CALC.
- CALC: ready_o=0, busy_o=1.
  - Window k is {b[4k+3:4k], b[4k-1]}, with b[-1]=0.
  - Booth_Ctrl(a_reg, window) produces pp, LENGTH+4 bits, signed.
  - acc <= acc + (sext(pp) << 4k), computed modulo 2^(2*LENGTH).
  - k increments each cycle. After the add for k=NWIN-1, go to DONE.
- DONE: valid_o=1 and p_o=acc. p_o is held stable while valid_o & !ready_i.
  - On ready_i, the product is consumed.
  - ready_o = ready_i in DONE, giving a same-cycle hand-over.
  - valid_i & ready_i together: load the new operands and go directly to CALC, with no IDLE bubble.
  - ready_i without valid_i: go to IDLE.
- Latency: handshake accepted on edge T. CALC occupies cycles T+1..T+NWIN. valid_o first goes high in cycle T+NWIN+1 (cycle 3 after acceptance for LENGTH=8).
- Throughput: one product per NWIN+1 cycles under continuous valid/ready.
- valid_i, a_i and b_i are ignored outside an accepting cycle. Changing a_i or b_i during CALC has no effect.
- p_o is exact for all operand pairs, including a=b=-2^(LENGTH-1).
- p_o is registered. It keeps its last value after consumption until the next DONE.

Decomposition:
- Package booth_r16_pkg holds:
  - state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - window width constant WIN_W=5;
  - function sext_shift(pp, k) returning a 2*LENGTH-bit value.
- Sub-module: exactly one Booth_Ctrl instance with .LENGTH(LENGTH), ports a_i(a_reg), b_i(window) and bo_o(pp).
- Window mux and accumulator stay inline in booth_r16_seq_ctrl.

Test Plan:
- LENGTH=8, a=5, b=8'h08: window0 gives d=-8 and window1 gives d=+1. Require p_o=16'd40, with valid_o first high 3 cycles after acceptance.
- a=8'h80, b=8'h80 -> p_o=16'h4000. a=8'h80, b=8'h7F -> p_o=16'hC080. a=8'hFF, b=8'h01 -> p_o=16'hFFFF.
- Backpressure: hold ready_i=0 for 5 cycles in DONE, toggling a_i/b_i. Require p_o stable, ready_o=0, and no new acceptance; the product transfers on the first ready_i.
- Back-to-back: valid_i=1 and ready_i=1 constantly with pairs (3,-7), (-1,-1), (127,127). Require outputs -21, 1 and 16129, one product every 3 cycles.
- Reset mid-op: assert rst_i in the 2nd CALC cycle. Require outputs at reset values immediately (asynchronous) and no valid_o. A subsequent (12,-12) gives -144.
- Random: 2000 signed pairs checked against $signed(a)*$signed(b). Run at LENGTH=8 and LENGTH=16.
